writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final (WB) stage of the 5-stage RISC-V pipeline core.
- Takes the MEM/WB bundle and selects the writeback value:
  - ALU result, or
  - formatted load data.
- Registers the selected value, with destination and commit strobe, toward the register file.
- Also gives the ID stage a combinational same-cycle forwarding path.
- Inputs come from the memory/writeback bundle; outputs drive the register-file write bundle.

Parameters:
- XLEN, 32, data width of address/LMD/rd_data.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-high (asserted = 1) despite the codebase name.
- mw_address  in  XLEN  ALU result from MEM/WB (memory address for loads).
- mw_lmd  in  XLEN  load memory data word from MEM/WB.
- mw_mem_to_reg  in  1  1 = write load data, 0 = write ALU result.
- mw_mem_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Tie to 010 when unused.
- rf_write_en  in  1  writeback requested this cycle.
- rf_rd_addr  in  REG_ADDR_W  destination register index.
- rf_rd_data  out  XLEN  registered writeback data.
- rf_wr_en_q  out  1  registered commit strobe to the register file.
- rf_wr_addr_q  out  REG_ADDR_W  registered destination index.
- fwd_valid  out  1  combinational: current WB result is forwardable.
- fwd_rd  out  REG_ADDR_W  combinational: rf_rd_addr.
- fwd_data  out  XLEN  combinational: wb_value.

Behaviour:

Load formatting, combinational, function of mw_lmd, mw_mem_funct3 and mw_address[1:0]:
- 010 (LW): mw_lmd passed unchanged. No alignment check.
- 000 / 100 (LB / LBU): byte lane selected by address[1:0] (00 = bits 7:0 … 11 = bits 31:24), then sign- or zero-extended to XLEN.
- 001 / 101 (LH / LHU): half selected by address[1] (0 = bits 15:0, 1 = bits 31:16), then sign- or zero-extended.
- address[0] is ignored for halves.
- Any other funct3 value: treated as LW.

Writeback selection, combinational:
- wb_value = mw_mem_to_reg ? load_formatted : mw_address.

Sequential update at each rising clk:
- Reset (rst_n = 1): rf_rd_data = 0, rf_wr_en_q = 0, rf_wr_addr_q = 0. Reset dominates write_en.
- rf_write_en = 1:
  - rf_rd_data <= wb_value.
  - rf_wr_addr_q <= rf_rd_addr.
  - rf_wr_en_q <= (rf_rd_addr != 0).
- rf_write_en = 0:
  - rf_rd_data and rf_wr_addr_q hold their previous values.
  - rf_wr_en_q <= 0.
  - Changes on mw_* are not reflected on rf_rd_data.
- Latency: one cycle from inputs to rf_rd_data / rf_wr_en_q.
- rf_wr_en_q is a single-cycle pulse per accepted write.

Register x0:
- Data is still captured into rf_rd_data.
- Strobe is suppressed, so x0 is never written.

Forwarding:
- fwd_valid = rf_write_en & (rf_rd_addr != 0) & ~rst_n.
- fwd_data and fwd_rd are valid the same cycle as the inputs.

Other rules:
- Reset mid-operation: outputs clear on the next edge; a pending write in that cycle is dropped.
- No handshake or stall: the stage accepts its inputs every cycle.
- Purely combinational except the three output registers.
- No latches.

Test Plan:
- Reset: rst_n = 1 for 1 cycle -> rf_rd_data = 0, rf_wr_en_q = 0, rf_wr_addr_q = 0.
- ALU path: address = 0x12345678, LMD = 0x87654321, mem_to_reg = 0, funct3 = 010, write_en = 1, rd = 1 -> after one edge: rf_rd_data = 0x12345678, rf_wr_addr_q = 1, rf_wr_en_q = 1.
- Load path: same data, mem_to_reg = 1, rd = 2 -> rf_rd_data = 0x87654321, rf_wr_addr_q = 2.
- Hold: write_en = 0, rd = 3, address = 0xDEADBEEF -> rf_rd_data stays 0x87654321 (≠ 0xDEADBEEF), rf_wr_en_q = 0.
- Load formatting, LMD = 0x87654321:
  - LB, addr[1:0] = 11 -> 0xFFFFFF87.
  - LBU, addr[1:0] = 00 -> 0x00000021.
  - LH, addr[1] = 1 -> 0xFFFF8765.
  - LHU, addr[1] = 0 -> 0x00004321.
- x0 / forwarding: write_en = 1, rd = 0 -> fwd_valid = 0, and after the edge rf_wr_en_q = 0. Then rd = 5 -> fwd_valid = 1 and fwd_data = wb_value in the same cycle.

Source files
------------

// File: rtl/writeback_if.sv
// MEM/WB bundle into the writeback stage and the register-file write and
// forwarding bundle out of it.
interface writeback_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic [XLEN-1:0]       mw_address;
    logic [XLEN-1:0]       mw_lmd;
    logic                  mw_mem_to_reg;
    logic [2:0]            mw_mem_funct3;
    logic                  rf_write_en;
    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [XLEN-1:0]       rf_rd_data;
    logic                  rf_wr_en_q;
    logic [REG_ADDR_W-1:0] rf_wr_addr_q;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]       fwd_data;

    modport master (
        output mw_address, mw_lmd, mw_mem_to_reg, mw_mem_funct3,
        output rf_write_en, rf_rd_addr,
        input  rf_rd_data, rf_wr_en_q, rf_wr_addr_q,
        input  fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  mw_address, mw_lmd, mw_mem_to_reg, mw_mem_funct3,
        input  rf_write_en, rf_rd_addr,
        output rf_rd_data, rf_wr_en_q, rf_wr_addr_q,
        output fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/writeback_stage.sv
// WB stage: formats load data, picks ALU or load result, registers it toward
// the register file and exposes a same-cycle forwarding path to ID.
module writeback_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    writeback_if.slave wb
);
    logic [XLEN-1:0]       ld_fmt_s;
    logic [XLEN-1:0]       wb_value_s;
    logic                  rd_nonzero_s;
    logic [XLEN-1:0]       rd_data_r;
    logic                  wr_en_r;
    logic [REG_ADDR_W-1:0] wr_addr_r;

    // Lane select plus extension; unknown funct3 codes fall back to a full word.
    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] lmd,
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (addr_lo)
            2'b00:   byte_v = lmd[7:0];
            2'b01:   byte_v = lmd[15:8];
            2'b10:   byte_v = lmd[23:16];
            2'b11:   byte_v = lmd[31:24];
            default: byte_v = lmd[7:0];
        endcase
        half_v = addr_lo[1] ? lmd[31:16] : lmd[15:0];
        case (funct3)
            3'b000:  return {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  return {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  return {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  return {{(XLEN-16){1'b0}}, half_v};
            default: return lmd;
        endcase
    endfunction

    // Writeback value selection.
    always_comb begin
        ld_fmt_s = format_load(wb.mw_lmd, wb.mw_mem_funct3, wb.mw_address[1:0]);
        if (wb.mw_mem_to_reg) begin
            wb_value_s = ld_fmt_s;
        end else begin
            wb_value_s = wb.mw_address;
        end
    end

    assign rd_nonzero_s = (wb.rf_rd_addr != {REG_ADDR_W{1'b0}});

    // Output registers; data is captured even for x0 but the strobe is not.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_data_r <= {XLEN{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {REG_ADDR_W{1'b0}};
        end else if (wb.rf_write_en) begin
            rd_data_r <= wb_value_s;
            wr_en_r   <= rd_nonzero_s;
            wr_addr_r <= wb.rf_rd_addr;
        end else begin
            rd_data_r <= rd_data_r;
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
        end
    end

    assign wb.rf_rd_data   = rd_data_r;
    assign wb.rf_wr_en_q   = wr_en_r;
    assign wb.rf_wr_addr_q = wr_addr_r;

    assign wb.fwd_valid = wb.rf_write_en & rd_nonzero_s & ~rst_n;
    assign wb.fwd_rd    = wb.rf_rd_addr;
    assign wb.fwd_data  = wb_value_s;
endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage against a behavioural model.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        en;
        logic [4:0]  addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_data = 32'd0;
    logic [4:0]  m_addr = 5'd0;

    writeback_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
    writeback_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [31:0] lmd, input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] v;
        case (f3)
            3'd0: begin
                v = (lmd >> (8 * a[1:0])) & 32'hFF;
                if (v >= 32'd128) v = v - 32'd256;
            end
            3'd4: v = (lmd >> (8 * a[1:0])) & 32'hFF;
            3'd1: begin
                v = (lmd >> (16 * a[1])) & 32'hFFFF;
                if (v >= 32'd32768) v = v - 32'd65536;
            end
            3'd5: v = (lmd >> (16 * a[1])) & 32'hFFFF;
            default: v = lmd;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step(input logic rst, input logic we, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] lmd,
                        input logic m2r, input logic [2:0] f3);
        logic [31:0] wv;
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        bus.rf_write_en = we;
        bus.rf_rd_addr = rd;
        bus.mw_address = addr;
        bus.mw_lmd = lmd;
        bus.mw_mem_to_reg = m2r;
        bus.mw_mem_funct3 = f3;
        wv = m2r ? ref_load(lmd, f3, addr) : addr;
        if (rst) begin
            m_data = 32'd0; m_addr = 5'd0; e.en = 1'b0;
        end else if (we) begin
            m_data = wv; m_addr = rd; e.en = (rd != 5'd0);
        end else begin
            e.en = 1'b0;
        end
        e.data = m_data;
        e.addr = m_addr;
        exp_q.push_back(e);
        #1;
        check("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, (we && rd != 5'd0 && !rst)});
        check("fwd_rd", {27'd0, bus.fwd_rd}, {27'd0, rd});
        check("fwd_data", bus.fwd_data, wv);
    endtask

    // Monitor: pops one expectation per clock edge after the DUT has updated.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_rd_data", bus.rf_rd_data, e.data);
                check("rf_wr_en_q", {31'd0, bus.rf_wr_en_q}, {31'd0, e.en});
                check("rf_wr_addr_q", {27'd0, bus.rf_wr_addr_q}, {27'd0, e.addr});
            end
        end
    end

    initial begin
        int budget;
        rst_n = 1'b1;
        bus.rf_write_en = 1'b0;
        bus.rf_rd_addr = 5'd0;
        bus.mw_address = 32'd0;
        bus.mw_lmd = 32'd0;
        bus.mw_mem_to_reg = 1'b0;
        bus.mw_mem_funct3 = 3'b010;
        // Directed cases from the test plan.
        step(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 3'b010);
        step(1'b0, 1'b1, 5'd1, 32'h1234_5678, 32'h8765_4321, 1'b0, 3'b010);
        step(1'b0, 1'b1, 5'd2, 32'h1234_5678, 32'h8765_4321, 1'b1, 3'b010);
        step(1'b0, 1'b0, 5'd3, 32'hDEAD_BEEF, 32'h8765_4321, 1'b0, 3'b010);
        step(1'b0, 1'b1, 5'd4, 32'h0000_0003, 32'h8765_4321, 1'b1, 3'b000);
        step(1'b0, 1'b1, 5'd4, 32'h0000_0000, 32'h8765_4321, 1'b1, 3'b100);
        step(1'b0, 1'b1, 5'd4, 32'h0000_0002, 32'h8765_4321, 1'b1, 3'b001);
        step(1'b0, 1'b1, 5'd4, 32'h0000_0000, 32'h8765_4321, 1'b1, 3'b101);
        step(1'b0, 1'b1, 5'd0, 32'hCAFE_0001, 32'h8765_4321, 1'b0, 3'b010);
        step(1'b0, 1'b1, 5'd5, 32'hCAFE_0002, 32'h8765_4321, 1'b0, 3'b010);
        step(1'b1, 1'b1, 5'd6, 32'h5555_AAAA, 32'h8765_4321, 1'b0, 3'b010);
        // Random traffic with occasional reset and all funct3 codes.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
